// File: rtl/imem_pkg.sv
// ============================================================================
// Module   : imem_pkg
// Brief    : Shared constants and FSM state encoding for the instruction loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int unsigned DEF_MEM_BYTES  = 136;
    localparam int unsigned BYTES_PER_INST = 4;
    localparam logic [63:0] DEF_BASE_ADDR  = 64'd0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_WRITE     = 3'd2,
        S_DONE      = 3'd3,
        S_ERR       = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Brief    : Word-stream, memory-write and status bundle of the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int ADDR_W = 64
) ();

    logic              start;
    logic              word_valid;
    logic [31:0]       word_data;
    logic              word_last;
    logic              word_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-3:0] word_count;

    // Producer / supervisor side.
    modport master (
        output start, word_valid, word_data, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, busy, done, error, word_count
    );

    // Loader side.
    modport slave (
        input  start, word_valid, word_data, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, busy, done, error, word_count
    );

endinterface

`default_nettype wire

// File: rtl/imem_byte_serializer.sv
// ============================================================================
// Module   : imem_byte_serializer
// Brief    : Emits a latched 32-bit word as four little-endian bytes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_byte_serializer (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_load,
    input  wire logic [31:0] i_word,
    output logic             o_valid,
    output logic [1:0]       o_idx,
    output logic [7:0]       o_byte,
    output logic             o_last
);

    logic        r_valid;
    logic [1:0]  r_idx;
    logic [31:0] r_word;

    // The word is shifted right so the current byte is always in bits [7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_idx   <= 2'd0;
            r_word  <= 32'd0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_idx   <= 2'd0;
            r_word  <= i_word;
        end else if (r_valid) begin
            r_word <= {8'h00, r_word[31:8]};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_idx   = r_idx;
    assign o_byte  = r_word[7:0];
    assign o_last  = (r_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time writer of the byte-addressed instruction memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned       MEM_BYTES = DEF_MEM_BYTES,
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR)
) (
    input  wire logic    clk,
    input  wire logic    reset,
    imem_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_word_bytes = ADDR_W'(BYTES_PER_INST);
    localparam logic [ADDR_W-1:0] c_limit      = BASE_ADDR + ADDR_W'(MEM_BYTES);
    localparam logic              c_fits_base  = (BASE_ADDR + c_word_bytes) <= c_limit;
    localparam logic [ADDR_W-3:0] c_count_one  = (ADDR_W-2)'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-3:0] r_count;
    logic              r_last;
    logic              r_word_ready;
    logic              r_busy;
    logic              r_hold;
    logic              r_done;
    logic              r_error;

    logic              w_accept;
    logic              w_ser_valid;
    logic [1:0]        w_ser_idx;
    logic [7:0]        w_ser_byte;
    logic              w_ser_last;
    logic [ADDR_W-1:0] w_ptr_next;
    logic              w_fits_next;
    logic [ADDR_W-1:0] w_idx_ext;

    assign w_accept    = (r_state == S_WAIT_WORD) && r_word_ready && bus.word_valid;
    assign w_ptr_next  = r_ptr + c_word_bytes;
    assign w_fits_next = (w_ptr_next + c_word_bytes) <= c_limit;
    assign w_idx_ext   = {{(ADDR_W-2){1'b0}}, w_ser_idx};

    imem_byte_serializer u_ser (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_word (bus.word_data),
        .o_valid(w_ser_valid),
        .o_idx  (w_ser_idx),
        .o_byte (w_ser_byte),
        .o_last (w_ser_last)
    );

    // word_ready is precomputed on entry to WAIT_WORD from the pointer it will hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= BASE_ADDR;
            r_count      <= '0;
            r_last       <= 1'b0;
            r_word_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_hold       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (bus.start) begin
                        r_state      <= S_WAIT_WORD;
                        r_ptr        <= BASE_ADDR;
                        r_count      <= '0;
                        r_error      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_hold       <= 1'b1;
                        r_word_ready <= c_fits_base;
                    end
                end
                S_WAIT_WORD: begin
                    if (r_word_ready) begin
                        if (bus.word_valid) begin
                            r_state      <= S_WRITE;
                            r_last       <= bus.word_last;
                            r_word_ready <= 1'b0;
                        end
                    end else if (bus.word_valid) begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_ser_valid && w_ser_last) begin
                        r_ptr   <= w_ptr_next;
                        r_count <= r_count + c_count_one;
                        if (r_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_WAIT_WORD;
                            r_word_ready <= w_fits_next;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_hold  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_word_ready <= 1'b0;
                    r_busy       <= 1'b0;
                    r_hold       <= 1'b0;
                    r_error      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_ready = r_word_ready;
    assign bus.cpu_hold   = r_hold;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.word_count = r_count;
    assign bus.mem_we     = w_ser_valid;
    assign bus.mem_addr   = w_ser_valid ? (r_ptr + w_idx_ext) : '0;
    assign bus.mem_wdata  = w_ser_valid ? w_ser_byte : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader (136-byte and 8-byte builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        start;
    logic        valid;
    logic        last;
    logic [31:0] data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0      = 0;

    logic [7:0] mem [0:255];

    imem_loader_if #(.ADDR_W(64)) bus ();
    imem_loader_if #(.ADDR_W(64)) bus_s ();

    imem_loader #(.MEM_BYTES(136), .ADDR_W(64), .BASE_ADDR(64'd0)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    imem_loader #(.MEM_BYTES(8), .ADDR_W(64), .BASE_ADDR(64'd0)) dut_s (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_s)
    );

    // Stimulus goes only to the selected instance.
    assign bus.start        = start & ~sel;
    assign bus.word_valid   = valid & ~sel;
    assign bus.word_data    = data;
    assign bus.word_last    = last;
    assign bus_s.start      = start & sel;
    assign bus_s.word_valid = valid & sel;
    assign bus_s.word_data  = data;
    assign bus_s.word_last  = last;

    logic        o_we, o_ready, o_hold, o_busy, o_done, o_error;
    logic [63:0] o_addr;
    logic [7:0]  o_wdata;
    logic [61:0] o_count;

    assign o_we    = sel ? bus_s.mem_we     : bus.mem_we;
    assign o_addr  = sel ? bus_s.mem_addr   : bus.mem_addr;
    assign o_wdata = sel ? bus_s.mem_wdata  : bus.mem_wdata;
    assign o_ready = sel ? bus_s.word_ready : bus.word_ready;
    assign o_hold  = sel ? bus_s.cpu_hold   : bus.cpu_hold;
    assign o_busy  = sel ? bus_s.busy       : bus.busy;
    assign o_done  = sel ? bus_s.done       : bus.done;
    assign o_error = sel ? bus_s.error      : bus.error;
    assign o_count = sel ? bus_s.word_count : bus.word_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 64'(o_busy), 64'd1);
        check("start_hold", 64'(o_hold), 64'd1);
    endtask

    // Called in a WAIT_WORD cycle; disturb keeps valid up and pulses start mid-write.
    task automatic write_word(input logic [31:0] d, input logic l, input logic [63:0] a,
                              input bit disturb);
        check("ready_before_accept", 64'(o_ready), 64'd1);
        valid = 1'b1;
        data  = d;
        last  = l;
        tick();
        if (disturb) begin
            data = 32'hDEADBEEF;
            last = 1'b1;
        end else begin
            valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            check("write_we",    64'(o_we),    64'd1);
            check("write_addr",  o_addr,       a + 64'(i));
            check("write_data",  64'(o_wdata), 64'(d[8*i +: 8]));
            check("write_ready", 64'(o_ready), 64'd0);
            start = disturb && (i == 1);
            tick();
        end
        start = 1'b0;
        valid = 1'b0;
    endtask

    task automatic check_done(input logic [63:0] cnt);
        check("done_pulse", 64'(o_done),  64'd1);
        check("done_hold",  64'(o_hold),  64'd1);
        check("done_we",    64'(o_we),    64'd0);
        check("done_count", 64'(o_count), cnt);
        tick();
        check("after_done_pulse", 64'(o_done), 64'd0);
        check("after_done_hold",  64'(o_hold), 64'd0);
        check("after_done_busy",  64'(o_busy), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"},    64'(o_we),    64'd0);
        check({tag, "_addr"},  o_addr,       64'd0);
        check({tag, "_wdata"}, 64'(o_wdata), 64'd0);
        check({tag, "_ready"}, 64'(o_ready), 64'd0);
        check({tag, "_hold"},  64'(o_hold),  64'd0);
        check({tag, "_busy"},  64'(o_busy),  64'd0);
        check({tag, "_done"},  64'(o_done),  64'd0);
        check({tag, "_error"}, 64'(o_error), 64'd0);
        check({tag, "_count"}, 64'(o_count), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        sel   = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        data  = 32'd0;
        #12;
        check_quiet("reset");
        reset = 1'b0;
        tick();

        // Single word, last=1.
        start_session();
        write_word(32'h00000AB3, 1'b1, 64'd0, 1'b0);
        check_done(64'd1);

        // Three words, valid held high, start pulsed during writes.
        start_session();
        c0 = cyc;
        write_word(32'h00800B13, 1'b0, 64'd0, 1'b1);
        write_word(32'h000009B3, 1'b0, 64'd4, 1'b1);
        write_word(32'h0169C463, 1'b1, 64'd8, 1'b1);
        check("accept_to_done_cycles", 64'(cyc - c0), 64'd15);
        check_done(64'd3);
        check("mem_w0", 64'({mem[3],  mem[2],  mem[1],  mem[0]}), 64'h00800B13);
        check("mem_w1", 64'({mem[7],  mem[6],  mem[5],  mem[4]}), 64'h000009B3);
        check("mem_w2", 64'({mem[11], mem[10], mem[9],  mem[8]}), 64'h0169C463);

        // Producer gaps of three cycles between words.
        start_session();
        write_word(32'h00800B13, 1'b0, 64'd0, 1'b0);
        repeat (3) begin
            check("gap_we",    64'(o_we),    64'd0);
            check("gap_ready", 64'(o_ready), 64'd1);
            tick();
        end
        write_word(32'h000009B3, 1'b0, 64'd4, 1'b0);
        repeat (3) begin
            check("gap_we",    64'(o_we),    64'd0);
            check("gap_busy",  64'(o_busy),  64'd1);
            tick();
        end
        write_word(32'h0169C463, 1'b1, 64'd8, 1'b0);
        check_done(64'd3);

        // Async reset while byte 2 of the second word is on the bus.
        start_session();
        write_word(32'h11223344, 1'b0, 64'd0, 1'b0);
        valid = 1'b1;
        data  = 32'h55667788;
        last  = 1'b0;
        tick();
        valid = 1'b0;
        tick();
        tick();
        check("pre_reset_we",   64'(o_we),   64'd1);
        check("pre_reset_addr", o_addr,      64'd6);
        #2;
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("mem_after_abort_w0", 64'({mem[3], mem[2], mem[1], mem[0]}), 64'h11223344);
        check("mem_after_abort_w1", 64'({mem[7], mem[6], mem[5], mem[4]}), 64'h00007788);
        start_session();
        write_word(32'h0169C463, 1'b1, 64'd0, 1'b0);
        check_done(64'd1);

        // Overflow on the 8-byte instance.
        sel = 1'b1;
        #1;
        start_session();
        write_word(32'h00800B13, 1'b0, 64'd0, 1'b0);
        write_word(32'h000009B3, 1'b0, 64'd4, 1'b0);
        check("full_ready", 64'(o_ready), 64'd0);
        check("full_busy",  64'(o_busy),  64'd1);
        check("full_error", 64'(o_error), 64'd0);
        check("full_count", 64'(o_count), 64'd2);
        valid = 1'b1;
        data  = 32'h0169C463;
        last  = 1'b0;
        tick();
        check("ovf_error", 64'(o_error), 64'd1);
        check("ovf_hold",  64'(o_hold),  64'd1);
        check("ovf_busy",  64'(o_busy),  64'd0);
        check("ovf_ready", 64'(o_ready), 64'd0);
        check("ovf_we",    64'(o_we),    64'd0);
        tick();
        check("ovf_sticky", 64'(o_error), 64'd1);
        check("ovf_no_we",  64'(o_we),    64'd0);
        valid = 1'b0;
        start_session();
        check("restart_error", 64'(o_error), 64'd0);
        check("restart_count", 64'(o_count), 64'd0);
        write_word(32'h0169C463, 1'b1, 64'd0, 1'b0);
        check_done(64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-addressed, little-endian instruction memory; fills it at boot from a 32-bit word stream (UART/JTAG bridge or testbench).
- Splits each accepted word into four byte writes at consecutive addresses, low byte first.
- Holds the CPU via cpu_hold while loading; releases it on completion.
- Flags overflow when the stream exceeds memory capacity.

Parameters:
- MEM_BYTES, 136, instruction memory size in bytes; multiple of 4.
- ADDR_W, 64, width of the memory address, matching the 64-bit instruction address.
- BASE_ADDR, 0, byte address of the first written word; word-aligned.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load session from BASE_ADDR
- word_valid  input  1  word_data/word_last valid
- word_data  input  32  instruction word
- word_last  input  1  final word of the program
- word_ready  output  1  loader accepts a word this cycle
- mem_we  output  1  byte write strobe
- mem_addr  output  ADDR_W  byte address of write
- mem_wdata  output  8  byte to write
- cpu_hold  output  1  keeps the CPU PC/fetch frozen
- busy  output  1  session in progress
- done  output  1  one-cycle pulse when the last byte is written
- error  output  1  sticky overflow flag
- word_count  output  ADDR_W-2  words fully written in the current or last session

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; write pointer=BASE_ADDR; byte index=0; word_count=0.
- Reset mid-session aborts at once; no further mem_we. A partially written word stays in memory. The loader does not clear memory.
- FSM states: IDLE, WAIT_WORD, WRITE, DONE, ERR.
- IDLE:
  - start=1 -> WAIT_WORD next cycle.
  - On that transition: pointer=BASE_ADDR, word_count=0, error cleared.
  - cpu_hold=0, busy=0.
- WAIT_WORD:
  - busy=1, cpu_hold=1.
  - If pointer+4 <= BASE_ADDR+MEM_BYTES: word_ready=1. On word_valid: latch word_data and word_last -> WRITE, byte index 0.
  - Otherwise: word_ready=0. word_valid=1 -> ERR. Otherwise wait.
- WRITE: one byte per cycle, exactly 4 cycles.
  - mem_we=1, mem_addr=pointer+idx, mem_wdata=word[8*idx+7:8*idx].
  - Byte order: idx0=bits[7:0] ... idx3=bits[31:24] (little-endian).
  - After idx3: pointer+=4, word_count+=1. Then latched last=1 -> DONE, otherwise WAIT_WORD.
  - word_ready=0 throughout.
- Throughput: 5 cycles per word (1 accept + 4 writes). First mem_we is the cycle after acceptance.
- DONE: done=1 for exactly one cycle, cpu_hold=1 -> IDLE. cpu_hold falls the cycle after the done pulse.
- ERR:
  - error=1, cpu_hold=1, busy=0, word_ready=0, no writes.
  - Stays in ERR until start (-> WAIT_WORD, error cleared) or reset.
- start while busy (WAIT_WORD/WRITE/DONE) is ignored.
- word_valid outside WAIT_WORD is ignored; the producer must hold the word until word_ready.
- Address arithmetic is ADDR_W-bit unsigned. BASE_ADDR+MEM_BYTES never wraps by construction.
- mem_addr and mem_wdata are 0 whenever mem_we=0.

Decomposition:
- Shared package (imem_pkg): MEM_BYTES default, BYTES_PER_INST=4, the FSM state enum, BASE_ADDR default.
- One natural sub-module: imem_byte_serializer. It takes a latched 32-bit word plus a load strobe and emits 4 little-endian bytes with idx and a last-byte flag. The FSM and address pointer stay in the top.

Test Plan:
- Single word: start, then word 0x00000AB3 with last=1 -> writes at addr 0..3 of B3,0A,00,00 on 4 consecutive cycles starting 1 cycle after accept. Then done pulse, word_count=1, cpu_hold falls the next cycle.
- Three words, back-to-back valid: 0x00800B13, 0x000009B3, 0x0169C463 (last on the 3rd) -> word_ready high only in WAIT_WORD cycles. 12 writes at addr 0..11, 15 cycles from first accept to last write, word_count=3.
- Overflow, MEM_BYTES=8: 3 words, none marked last -> 8 bytes written, third word not accepted, error=1, cpu_hold=1. A new start clears error and restarts at addr 0.
- Async reset during WRITE idx2 of word 2 -> mem_we drops in the same cycle and all outputs are 0. Memory holds word 1 plus 2 bytes of word 2. A fresh start rewrites from addr 0.
- start pulsed during WRITE and word_valid held during WRITE -> no restart, no extra accepts; byte sequence unchanged.
- Producer gaps: word_valid deasserted 3 cycles between words -> loader waits in WAIT_WORD with no writes; contents match the gap-free run.
